// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the 16-bit controller and the peripheral-side receiver.
//   SPI_WORD_W  : frame length in bits shared by both ends of the link
//   spi_state_e : receiver frame FSM states
package spi_pkg;

  localparam int unsigned SPI_WORD_W = 16;

  typedef enum logic [1:0] {
    DISARMED,
    IDLE,
    ACTIVE
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with registered edge detection for one asynchronous pin.
//   clk_i : system clock
//   rst_i : synchronous active-high reset (all stages clear to 0)
//   d     : asynchronous input pin
//   q     : SYNC_STAGES-delayed copy of d
//   rise  : 1-cycle pulse, registered one stage after q goes 0->1
//   fall  : 1-cycle pulse, registered one stage after q goes 1->0
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_16bit_slave_rx.sv
// SPI peripheral-side receive endpoint (mode 0, MSB first), oversampled on clk_i.
//   clk_i     : system clock, must run >= 4x spi_sclk
//   rst_i     : synchronous active-high reset
//   spi_sclk  : SPI clock from the controller (async, idles low)
//   spi_mosi  : serial data in, MSB first (async)
//   spi_cs    : chip select, active low (async)
//   spi_miso  : serial data out, MSB first; 0 outside a frame
//   tx_data   : word returned in the next frame
//   tx_load   : 1-cycle strobe capturing tx_data into the holding register
//   rx_data   : last good received word
//   rx_valid  : 1-cycle strobe, rx_data just updated
//   frame_err : 1-cycle strobe, a frame closed with a bad bit count
//   busy      : frame in progress
module spi_16bit_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_WORD_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRICT_LEN  = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned       CntW    = $clog2(DATA_W + 2);
  localparam logic [CntW-1:0]   CntFull = CntW'(DATA_W);
  localparam logic [CntW-1:0]   CntSat  = CntW'(DATA_W + 1);

  // Pin conditioning
  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sclk (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d    (spi_sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_cs (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d    (spi_cs),
    .q    (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // Only the edge pulses of sclk are consumed; the level is kept for debug visibility.
  logic unused_sclk_s;
  assign unused_sclk_s = sclk_s;

  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  // State
  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;

  // Count and shift after this cycle's sclk rise, so a rise coinciding with
  // cs_rise is included before the frame is judged.
  logic [CntW-1:0]   cnt_after;
  logic [DATA_W-1:0] shift_after;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= DISARMED;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_hold_q   <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      mosi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      rx_data_q   <= rx_data_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  // Next-state logic. DISARMED waits for a deasserted cs so a frame already
  // running when reset releases is never captured.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DISARMED: if (cs_s)    state_d = IDLE;
      IDLE:     if (cs_fall) state_d = ACTIVE;
      ACTIVE:   if (cs_rise) state_d = IDLE;
      default:               state_d = DISARMED;
    endcase
  end

  // Datapath and strobes
  always_comb begin
    cnt_after   = bit_cnt_q;
    shift_after = rx_shift_q;
    if (sclk_rise) begin
      if (bit_cnt_q < CntFull) begin
        shift_after = {rx_shift_q[DATA_W-2:0], mosi_s};
        cnt_after   = bit_cnt_q + CntW'(1);
      end else begin
        cnt_after   = CntSat;
      end
    end

    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    miso_d      = 1'b0;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    // A load coinciding with cs_fall feeds the new word straight into the frame.
    tx_hold_d   = tx_load ? tx_data : tx_hold_q;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d  = '0;
          tx_shift_d = tx_hold_d;
          miso_d     = tx_hold_d[DATA_W-1];
        end
      end
      ACTIVE: begin
        bit_cnt_d  = cnt_after;
        rx_shift_d = shift_after;
        miso_d     = miso_q;
        // The first MSB is already on the pin; shift only between bits.
        if (sclk_fall && (bit_cnt_q != '0) && (bit_cnt_q < CntFull)) begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          miso_d     = tx_shift_q[DATA_W-2];
        end
        if (cs_rise) begin
          miso_d = 1'b0;
          if ((cnt_after == CntFull) || ((cnt_after > CntFull) && (STRICT_LEN == 0))) begin
            rx_data_d  = shift_after;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    spi_miso  = miso_q;
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    frame_err = frame_err_q;
    busy      = (state_q == ACTIVE);
  end

endmodule

// File: tb/tb_spi_16bit_slave_rx.sv
module tb_spi_16bit_slave_rx;

  localparam int unsigned SyncStages = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        spi_sclk, spi_mosi, spi_cs;
  logic [15:0] tx_data;
  logic        tx_load;

  logic        miso0, rx_valid0, frame_err0, busy0;
  logic [15:0] rx_data0;
  logic        miso1, rx_valid1, frame_err1, busy1;
  logic [15:0] rx_data1;

  always #5 clk = ~clk;

  spi_16bit_slave_rx #(
    .DATA_W     (16),
    .SYNC_STAGES(SyncStages),
    .STRICT_LEN (0)
  ) u_dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_cs   (spi_cs),
    .spi_miso (miso0),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data0),
    .rx_valid (rx_valid0),
    .frame_err(frame_err0),
    .busy     (busy0)
  );

  spi_16bit_slave_rx #(
    .DATA_W     (16),
    .SYNC_STAGES(SyncStages),
    .STRICT_LEN (1)
  ) u_dut_strict (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_cs   (spi_cs),
    .spi_miso (miso1),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data1),
    .rx_valid (rx_valid1),
    .frame_err(frame_err1),
    .busy     (busy1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Observed strobes
  logic [15:0] got0[$];
  logic [15:0] got1[$];
  int          e0_cnt = 0;
  int          e1_cnt = 0;
  int          overlap_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid0) got0.push_back(rx_data0);
    if (rx_valid1) got1.push_back(rx_data1);
    if (frame_err0) e0_cnt++;
    if (frame_err1) e1_cnt++;
    if ((rx_valid0 && frame_err0) || (rx_valid1 && frame_err1)) overlap_cnt++;
  end

  // Reference model state
  logic [15:0] tx_hold_m = 16'h0;
  logic [15:0] exp_rx0 = 16'h0;
  logic [15:0] exp_rx1 = 16'h0;
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  int          exp_err0 = 0;
  int          exp_err1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_tx(input logic [15:0] val);
    tx_data = val;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    tx_hold_m = val;
  endtask

  // One frame of nbits sclk periods (sclk = clk/8). load_at: -1 none, -2 with cs_fall,
  // k = after bit k. rst_at: -1 none, k = pulse reset after bit k.
  task automatic run_frame(input logic [31:0] bits, input int nbits, input int load_at,
                           input logic [15:0] load_val, input int rst_at, input int gap,
                           input string tag);
    logic [15:0] mw0, mw1, exp_miso, word;
    bit          did_rst;
    mw0 = '0;
    mw1 = '0;
    did_rst = 1'b0;
    exp_miso = tx_hold_m;
    spi_cs = 1'b0;
    if (load_at == -2) begin
      repeat (SyncStages + 1) @(negedge clk);
      load_tx(load_val);
      exp_miso = load_val;
      repeat (4) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = bits[nbits-1-i];
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      if (i < 16) begin
        mw0[15-i] = miso0;
        mw1[15-i] = miso1;
      end
      if (i == 7 && rst_at < 0) begin
        chk($sformatf("%s:busy_mid", tag), 32'(busy0), 32'd1);
        chk($sformatf("%s:busy_mid_strict", tag), 32'(busy1), 32'd1);
      end
      spi_sclk = 1'b0;
      if (i == load_at) load_tx(load_val);
      if (i == rst_at) begin
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        chk($sformatf("%s:rst_busy", tag), 32'(busy0), 32'd0);
        chk($sformatf("%s:rst_miso", tag), 32'(miso0), 32'd0);
        chk($sformatf("%s:rst_rx_data", tag), 32'(rx_data0), 32'd0);
        chk($sformatf("%s:rst_strobes", tag), 32'({rx_valid0, frame_err0}), 32'd0);
        rst_i = 1'b0;
        did_rst = 1'b1;
        tx_hold_m = 16'h0;
        exp_rx0 = 16'h0;
        exp_rx1 = 16'h0;
      end
    end
    repeat (4) @(negedge clk);
    spi_cs = 1'b1;
    repeat (gap) @(negedge clk);

    if (!did_rst) begin
      if (nbits >= 16) begin
        chk($sformatf("%s:miso", tag), 32'(mw0), 32'(exp_miso));
        chk($sformatf("%s:miso_strict", tag), 32'(mw1), 32'(exp_miso));
        word = 16'(bits >> (nbits - 16));
        exp0.push_back(word);
        exp_rx0 = word;
      end else begin
        exp_err0++;
      end
      if (nbits == 16) begin
        exp1.push_back(word);
        exp_rx1 = word;
      end else begin
        exp_err1++;
      end
    end
  endtask

  task automatic checkpoint(input string tag);
    chk($sformatf("%s:n_valid", tag), 32'(got0.size()), 32'(exp0.size()));
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      chk($sformatf("%s:word%0d", tag, i), 32'(got0[i]), 32'(exp0[i]));
    chk($sformatf("%s:n_err", tag), 32'(e0_cnt), 32'(exp_err0));
    chk($sformatf("%s:rx_data", tag), 32'(rx_data0), 32'(exp_rx0));
    chk($sformatf("%s:n_valid_strict", tag), 32'(got1.size()), 32'(exp1.size()));
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      chk($sformatf("%s:word%0d_strict", tag, i), 32'(got1[i]), 32'(exp1[i]));
    chk($sformatf("%s:n_err_strict", tag), 32'(e1_cnt), 32'(exp_err1));
    chk($sformatf("%s:rx_data_strict", tag), 32'(rx_data1), 32'(exp_rx1));
    chk($sformatf("%s:busy_idle", tag), 32'(busy0), 32'd0);
    chk($sformatf("%s:miso_idle", tag), 32'(miso0), 32'd0);
    got0.delete();
    got1.delete();
    exp0.delete();
    exp1.delete();
  endtask

  initial begin
    logic [31:0] rnd;
    int          nb;
    rst_i    = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_cs   = 1'b1;
    tx_data  = 16'h0;
    tx_load  = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset:miso", 32'(miso0), 32'd0);
    chk("reset:rx_data", 32'(rx_data0), 32'd0);
    chk("reset:rx_valid", 32'(rx_valid0), 32'd0);
    chk("reset:frame_err", 32'(frame_err0), 32'd0);
    chk("reset:busy", 32'(busy0), 32'd0);
    rst_i = 1'b0;
    repeat (10) @(negedge clk);

    // Basic frame with a preloaded response word
    load_tx(16'hBEEF);
    run_frame(32'hA5C3, 16, -1, 16'h0, -1, 10, "basic");
    checkpoint("basic");

    // Short frame
    rnd = $urandom;
    run_frame(rnd & 32'h7FFF, 15, -1, 16'h0, -1, 10, "short15");
    checkpoint("short15");

    // Over-length frame: 0x1234 then a trailing 1
    run_frame(32'h2469, 17, -1, 16'h0, -1, 10, "long17");
    checkpoint("long17");

    // Reset after bit 8 while cs stays low, then a clean frame
    rnd = $urandom;
    run_frame(rnd & 32'hFFFF, 16, -1, 16'h0, 7, 10, "rst_mid");
    checkpoint("rst_mid");
    run_frame(32'h00FF, 16, -1, 16'h0, -1, 10, "after_rst");
    checkpoint("after_rst");

    // Load coinciding with cs_fall bypasses into the frame
    load_tx(16'hBEEF);
    rnd = $urandom;
    run_frame(rnd & 32'hFFFF, 16, -2, 16'h0001, -1, 10, "bypass");
    checkpoint("bypass");

    // Mid-frame load leaves the current frame alone, then shows up in the next
    rnd = $urandom;
    run_frame(rnd & 32'hFFFF, 16, 5, 16'hFFFF, -1, 10, "midload");
    checkpoint("midload");

    // Back-to-back with the minimum cs-high gap
    run_frame(32'h8001, 16, -1, 16'h0, -1, SyncStages + 2, "b2b_a");
    run_frame(32'h7FFE, 16, -1, 16'h0, -1, 10, "b2b_b");
    checkpoint("b2b");

    // Randomized frames
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) load_tx(16'($urandom));
      nb  = $urandom_range(15, 17);
      rnd = $urandom;
      rnd = rnd & ((32'd1 << nb) - 32'd1);
      run_frame(rnd, nb, -1, 16'h0, -1, 10, $sformatf("rand%0d", k));
      checkpoint($sformatf("rand%0d", k));
    end

    chk("no_overlap", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
